// File: rtl/round_sequencer_pkg.sv
// Shared definitions for the round sequencer, display mux and CountDownTimer.
// Holds the phase encoding seen on the phase output and the level width.
package round_sequencer_pkg;

    localparam int unsigned LEVEL_W = 4;
    localparam int unsigned PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_SHOW = 3'd1,
        ST_PLAY = 3'd2,
        ST_PASS = 3'd3,
        ST_FAIL = 3'd4,
        ST_OVER = 3'd5,
        ST_WIN  = 3'd6
    } state_e;

endpackage

// File: rtl/round_sequencer_btn_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// A level change on btn_in shows up as a one-cycle pulse_out three cycles later.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic pulse_out
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic pulse_q, pulse_d;

    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        pulse_d = sync2_q & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_out = pulse_q;

endmodule

// File: rtl/round_sequencer.sv
// Game-flow controller: selects the level, arms CountDownTimer and reacts to
// answers or timeout. Display phases are timed in Clk1Hz enable pulses.
module round_sequencer
    import round_sequencer_pkg::*;
#(
    parameter int unsigned MAX_LEVEL   = 15,
    parameter int unsigned SHOW_SECS   = 2,
    parameter int unsigned RESULT_SECS = 3
) (
    input  logic               Clk100M,
    input  logic               nReset,
    input  logic               Clk1Hz,
    input  logic               btnGo,
    input  logic               answerValid,
    input  logic               answerCorrect,
    input  logic               doneCounting,
    output logic               start,
    output logic [LEVEL_W-1:0] curLevel,
    output logic [PHASE_W-1:0] phase,
    output logic               roundPass,
    output logic               gameOver,
    output logic               gameWon
);

    localparam int unsigned SEC_W = 8;

    state_e             state_q, state_d;
    logic [LEVEL_W-1:0] lvl_q, lvl_d;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic               pass_q, pass_d;
    logic               go_pulse;

    logic show_done;
    logic result_done;

    btn_sync_edge u_go_sync (
        .clk       (Clk100M),
        .rst_n     (nReset),
        .btn_in    (btnGo),
        .pulse_out (go_pulse)
    );

    assign show_done   = Clk1Hz && (sec_q == SEC_W'(SHOW_SECS - 1));
    assign result_done = Clk1Hz && (sec_q == SEC_W'(RESULT_SECS - 1));

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        sec_d   = sec_q;
        pass_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (go_pulse) begin
                    state_d = ST_SHOW;
                    lvl_d   = LEVEL_W'(1);
                end
            end
            ST_SHOW: begin
                if (show_done)   state_d = ST_PLAY;
                else if (Clk1Hz) sec_d   = sec_q + SEC_W'(1);
            end
            ST_PLAY: begin
                // An answer in the same cycle as timeout takes priority.
                if (answerValid) begin
                    state_d = answerCorrect ? ST_PASS : ST_FAIL;
                    pass_d  = answerCorrect;
                end else if (doneCounting) begin
                    state_d = ST_FAIL;
                end
            end
            ST_PASS: begin
                if (result_done) begin
                    if (lvl_q == LEVEL_W'(MAX_LEVEL)) begin
                        state_d = ST_WIN;
                    end else begin
                        state_d = ST_SHOW;
                        lvl_d   = lvl_q + LEVEL_W'(1);
                    end
                end else if (Clk1Hz) begin
                    sec_d = sec_q + SEC_W'(1);
                end
            end
            ST_FAIL: begin
                if (result_done) state_d = ST_OVER;
                else if (Clk1Hz) sec_d   = sec_q + SEC_W'(1);
            end
            ST_OVER, ST_WIN: begin
                if (go_pulse) begin
                    state_d = ST_SHOW;
                    lvl_d   = LEVEL_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Every phase starts counting seconds from zero.
        if (state_d != state_q) sec_d = '0;
    end

    always_ff @(posedge Clk100M or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_IDLE;
            lvl_q   <= LEVEL_W'(1);
            sec_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            sec_q   <= sec_d;
            pass_q  <= pass_d;
        end
    end

    assign start     = (state_q == ST_PLAY);
    assign curLevel  = lvl_q;
    assign phase     = state_q;
    assign roundPass = pass_q;
    assign gameOver  = (state_q == ST_OVER);
    assign gameWon   = (state_q == ST_WIN);

endmodule

// File: tb/tb_round_sequencer.sv
// Directed game scenarios with randomized timing and answer choices, checked
// against expectations derived from the game rules (level, phase, outputs).
module tb_round_sequencer;

    localparam int unsigned MAX_LV   = 15;
    localparam int unsigned SHOW_S   = 2;
    localparam int unsigned RESULT_S = 3;

    localparam int P_IDLE = 0, P_SHOW = 1, P_PLAY = 2, P_PASS = 3;
    localparam int P_FAIL = 4, P_OVER = 5, P_WIN = 6;

    logic       Clk100M = 1'b0;
    logic       nReset = 1'b0;
    logic       Clk1Hz = 1'b0;
    logic       btnGo = 1'b0;
    logic       answerValid = 1'b0;
    logic       answerCorrect = 1'b0;
    logic       doneCounting = 1'b0;
    logic       start;
    logic [3:0] curLevel;
    logic [2:0] phase;
    logic       roundPass;
    logic       gameOver;
    logic       gameWon;

    int total = 0;
    int bad = 0;
    int unsigned exp_level = 1;

    round_sequencer #(
        .MAX_LEVEL   (MAX_LV),
        .SHOW_SECS   (SHOW_S),
        .RESULT_SECS (RESULT_S)
    ) dut (
        .Clk100M       (Clk100M),
        .nReset        (nReset),
        .Clk1Hz        (Clk1Hz),
        .btnGo         (btnGo),
        .answerValid   (answerValid),
        .answerCorrect (answerCorrect),
        .doneCounting  (doneCounting),
        .start         (start),
        .curLevel      (curLevel),
        .phase         (phase),
        .roundPass     (roundPass),
        .gameOver      (gameOver),
        .gameWon       (gameWon)
    );

    always #5 Clk100M = ~Clk100M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge Clk100M);
        #1;
    endtask

    // One Clk1Hz enable pulse followed by a random idle gap.
    task automatic one_sec();
        Clk1Hz = 1'b1;
        cyc(1);
        Clk1Hz = 1'b0;
        cyc($urandom_range(0, 3));
    endtask

    task automatic do_go();
        int unsigned n;
        btnGo = 1'b1;
        n = 0;
        while (phase !== 3'(P_SHOW) && n < 20) begin
            cyc(1);
            n++;
        end
        chk("go_latency", n, 4);
        btnGo = 1'b0;
        exp_level = 1;
        chk("go_level", curLevel, exp_level);
        chk("go_over_clr", gameOver, 0);
        chk("go_won_clr", gameWon, 0);
    endtask

    task automatic do_show(input bit stale_done);
        chk("show_phase", phase, P_SHOW);
        chk("show_level", curLevel, exp_level);
        for (int unsigned s = 0; s < SHOW_S; s++) begin
            if (stale_done && s == 0) doneCounting = 1'b1;
            chk("show_hold", phase, P_SHOW);
            chk("show_start", start, 0);
            one_sec();
            doneCounting = 1'b0;
        end
        chk("play_phase", phase, P_PLAY);
        chk("play_start", start, 1);
    endtask

    task automatic do_pass(input bit with_done);
        cyc($urandom_range(0, 4));
        chk("play_wait", phase, P_PLAY);
        answerValid = 1'b1;
        answerCorrect = 1'b1;
        doneCounting = with_done;
        cyc(1);
        answerValid = 1'b0;
        answerCorrect = 1'b0;
        doneCounting = 1'b0;
        chk(with_done ? "pass_vs_done" : "pass_phase", phase, P_PASS);
        chk("pass_pulse", roundPass, 1);
        chk("pass_start", start, 0);
        answerValid = 1'b1;
        cyc(1);
        answerValid = 1'b0;
        chk("pass_pulse_end", roundPass, 0);
        chk("pass_ans_ignored", phase, P_PASS);
        for (int unsigned s = 0; s < RESULT_S; s++) begin
            chk("pass_hold", phase, P_PASS);
            one_sec();
        end
        if (exp_level == MAX_LV) begin
            chk("win_phase", phase, P_WIN);
            chk("win_flag", gameWon, 1);
            chk("win_level", curLevel, MAX_LV);
        end else begin
            exp_level++;
            chk("next_phase", phase, P_SHOW);
            chk("next_level", curLevel, exp_level);
        end
    endtask

    task automatic do_fail(input bit timeout);
        cyc($urandom_range(0, 4));
        if (timeout) doneCounting = 1'b1;
        else begin
            answerValid = 1'b1;
            answerCorrect = 1'b0;
        end
        cyc(1);
        answerValid = 1'b0;
        doneCounting = 1'b0;
        chk("fail_phase", phase, P_FAIL);
        chk("fail_start", start, 0);
        chk("fail_no_pass", roundPass, 0);
        for (int unsigned s = 0; s < RESULT_S; s++) begin
            chk("fail_hold", phase, P_FAIL);
            one_sec();
        end
        chk("over_phase", phase, P_OVER);
        chk("over_flag", gameOver, 1);
        chk("over_level", curLevel, exp_level);
    endtask

    initial begin
        cyc(3);
        chk("rst_phase", phase, P_IDLE);
        chk("rst_start", start, 0);
        chk("rst_level", curLevel, 1);
        chk("rst_pass", roundPass, 0);
        chk("rst_over", gameOver, 0);
        chk("rst_won", gameWon, 0);
        #3 nReset = 1'b1;
        cyc(3);
        one_sec();
        chk("idle_hold", phase, P_IDLE);

        // Level 1 pass with stale timeout during SHOW, then timeout at level 2.
        do_go();
        do_show(1'b1);
        do_pass(1'b0);
        do_show(1'b0);
        do_fail(1'b1);

        // Full game to WIN; go pressed during PLAY once, ignored.
        do_go();
        for (int unsigned lv = 1; lv <= MAX_LV; lv++) begin
            do_show($urandom_range(0, 1) == 1);
            if (lv == 2) begin
                btnGo = 1'b1;
                cyc(6);
                chk("go_ignored_play", phase, P_PLAY);
                btnGo = 1'b0;
                cyc(4);
            end
            do_pass(lv == 3 || $urandom_range(0, 2) == 0);
        end
        cyc(5);
        chk("win_stays", phase, P_WIN);

        // Restart from WIN, lose on a wrong answer at level 1.
        do_go();
        do_show(1'b0);
        do_fail(1'b0);

        // Reach level 4 then assert reset mid-PLAY.
        do_go();
        for (int unsigned lv = 1; lv <= 3; lv++) begin
            do_show(1'b0);
            do_pass(1'b0);
        end
        do_show(1'b0);
        chk("pre_rst_level", curLevel, 4);
        #1 nReset = 1'b0;
        #1;
        chk("async_rst_start", start, 0);
        chk("async_rst_level", curLevel, 1);
        chk("async_rst_phase", phase, P_IDLE);
        #1 nReset = 1'b1;
        cyc(3);
        chk("post_rst_phase", phase, P_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
